fetch_sequencer: RTL

//  Sequences instruction fetch for the Y86-64 sequential core. Owns the PC, reads instruction

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - Y86-64 byte-serial instruction fetch sequencer with valid/ready delivery
module fetch_sequencer #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] start_pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [0:79] current_instruction,
    output logic [63:0] instr_pc,
    output logic [3:0]  instr_len,
    input  logic        pc_update_valid,
    input  logic [63:0] pc_next,
    output logic        busy,
    output logic        halted,
    output logic        err_instr,
    output logic        err_addr
);

    typedef enum logic [2:0] {IDLE, FETCH, DELIVER, WAIT_PC, HALT, ERROR} state_t;

    state_t      state, state_next;
    logic [63:0] pc;
    logic [3:0]  idx;
    logic [3:0]  len;
    logic [0:79] instr_buf;
    logic [64:0] fetch_sum;
    logic        addr_oob;
    logic [3:0]  dec_len;
    logic [3:0]  cur_len;
    logic        bad_icode;
    logic        byte_last;
    logic        idle_like;

    // 65-bit sum so a wrap past 2^64 still counts as out of range
    assign fetch_sum = {1'b0, pc} + {61'd0, idx};
    assign addr_oob  = fetch_sum > 65'(MEM_BYTES - 1);

    always_comb begin
        dec_len = 4'd0;
        case (mem_rdata[7:4])
            4'h0, 4'h1, 4'h9:       dec_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: dec_len = 4'd2;
            4'h7, 4'h8:             dec_len = 4'd9;
            4'h3, 4'h4, 4'h5:       dec_len = 4'd10;
            default:                dec_len = 4'd0;
        endcase
    end

    assign bad_icode = (idx == 4'd0) && (dec_len == 4'd0);
    assign cur_len   = (idx == 4'd0) ? dec_len : len;
    assign byte_last = (idx + 4'd1) == cur_len;
    assign idle_like = (state == IDLE) || (state == HALT) || (state == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        case (state)
            IDLE, HALT, ERROR: if (start) state_next = FETCH;
            FETCH: begin
                if (addr_oob) begin
                    state_next = ERROR;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        if (bad_icode)      state_next = ERROR;
                        else if (byte_last) state_next = DELIVER;
                    end
                end
            end
            DELIVER: if (instr_ready) state_next = (instr_buf[0 +: 4] == 4'h0) ? HALT : WAIT_PC;
            WAIT_PC: if (pc_update_valid) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            idx       <= '0;
            len       <= '0;
            instr_buf <= '0;
            halted    <= 1'b0;
            err_instr <= 1'b0;
            err_addr  <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT, ERROR: begin
                    if (start) begin
                        pc        <= start_pc;
                        idx       <= '0;
                        len       <= '0;
                        instr_buf <= '0;
                        halted    <= 1'b0;
                        err_instr <= 1'b0;
                        err_addr  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (addr_oob) begin
                        err_addr <= 1'b1;
                    end else if (mem_ack) begin
                        if (bad_icode) begin
                            err_instr <= 1'b1;
                        end else begin
                            instr_buf[{idx, 3'b000} +: 8] <= mem_rdata;
                            if (idx == 4'd0) len <= dec_len;
                            if (!byte_last)  idx <= idx + 4'd1;
                        end
                    end
                end
                DELIVER: if (instr_ready && instr_buf[0 +: 4] == 4'h0) halted <= 1'b1;
                WAIT_PC: begin
                    if (pc_update_valid) begin
                        pc        <= pc_next;
                        idx       <= '0;
                        len       <= '0;
                        instr_buf <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr            = fetch_sum[63:0];
    assign instr_valid         = (state == DELIVER);
    assign busy                = !idle_like;
    assign current_instruction = instr_buf;
    assign instr_pc            = pc;
    assign instr_len           = len;

endmodule
